// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if
//
// Bundles the byte-stream handshake and the shared memory bus around the
// program loader.
//
// Signals:
//   rx_data / rx_valid / rx_ready  byte stream into the loader
//   cpu_address / cpu_data_out / cpu_we
//                                  CPU-side memory request
//   mem_address / mem_data_out / mem_we
//                                  memory-side request, driven by the loader
//
// Modports:
//   master  the environment: byte source, CPU and memory
//   slave   the loader itself
// ---------------------------------------------------------------------------
interface prog_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    logic [15:0] cpu_address;
    logic [31:0] cpu_data_out;
    logic        cpu_we;

    logic [15:0] mem_address;
    logic [31:0] mem_data_out;
    logic        mem_we;

    modport master (
        output rx_data, rx_valid, cpu_address, cpu_data_out, cpu_we,
        input  rx_ready, mem_address, mem_data_out, mem_we
    );

    modport slave (
        input  rx_data, rx_valid, cpu_address, cpu_data_out, cpu_we,
        output rx_ready, mem_address, mem_data_out, mem_we
    );
endinterface

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Boot/program loader that owns the single-port memory shared with the CPU.
// A byte stream carries a 16-bit big-endian word count followed by that many
// big-endian 32-bit words; each word is written to BASE_ADDR, BASE_ADDR+1, ...
// While loading, the CPU is held in reset; afterwards the memory port is a
// combinational pass-through from the CPU. Memory read data bypasses this
// block entirely.
//
// Parameters:
//   BASE_ADDR  word address of the first loaded word (wraps past 16'hFFFF)
//   BOOT_LOAD  1 = load after reset, 0 = release the CPU straight to run
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous, active-low
//   load_req      level request to (re)enter load mode from RUN
//   bus           stream + CPU/memory bus (slave side)
//   cpu_reset     active-high reset to the CPU, high whenever not in RUN
//   busy          high whenever not in RUN
//   words_loaded  words written in the current or last load
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter bit          BOOT_LOAD = 1'b1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_req,
    prog_loader_if.slave  bus,
    output logic          cpu_reset,
    output logic          busy,
    output logic [15:0]   words_loaded
);

    typedef enum logic [2:0] {
        HOLD,
        HDR_HI,
        HDR_LO,
        DATA,
        WRITE,
        RUN
    } state_t;

    state_t      state;
    state_t      state_n;

    logic [1:0]  byte_idx;
    logic [15:0] word_idx;
    logic [15:0] count;
    logic [31:0] shift;

    // Registered decodes of the state, updated together with it.
    logic        rx_ready_q;
    logic        write_q;

    logic        xfer;
    logic [15:0] count_full;
    logic [15:0] word_idx_inc;

    assign xfer         = bus.rx_valid & rx_ready_q;
    assign count_full   = {count[15:8], bus.rx_data};
    assign word_idx_inc = word_idx + 16'd1;

    // -----------------------------------------------------------------------
    // Next-state decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns state_n; no latch is inferred.
        state_n = state;
        unique case (state)
            HOLD: begin
                if (BOOT_LOAD || load_req) state_n = HDR_HI;
                else                       state_n = RUN;
            end
            HDR_HI: begin
                if (xfer) state_n = HDR_LO;
            end
            HDR_LO: begin
                // An empty image releases the CPU without a single write.
                if (xfer) state_n = (count_full == 16'd0) ? RUN : DATA;
            end
            DATA: begin
                if (xfer && byte_idx == 2'd3) state_n = WRITE;
            end
            WRITE: begin
                state_n = (word_idx_inc == count) ? RUN : DATA;
            end
            RUN: begin
                if (load_req) state_n = HOLD;
            end
            default: state_n = HOLD;
        endcase
    end

    // -----------------------------------------------------------------------
    // State, datapath and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= HOLD;
            byte_idx     <= 2'd0;
            word_idx     <= 16'd0;
            count        <= 16'd0;
            shift        <= 32'd0;
            words_loaded <= 16'd0;
            rx_ready_q   <= 1'b0;
            write_q      <= 1'b0;
            cpu_reset    <= 1'b1;
            busy         <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // pre-edge values regardless of statement order.
            state      <= state_n;
            rx_ready_q <= (state_n == HDR_HI) || (state_n == HDR_LO) || (state_n == DATA);
            write_q    <= (state_n == WRITE);
            cpu_reset  <= (state_n != RUN);
            busy       <= (state_n != RUN);

            unique case (state)
                HOLD: begin
                    // A fresh load starts counting from the first word again.
                    if (state_n == HDR_HI) begin
                        word_idx     <= 16'd0;
                        words_loaded <= 16'd0;
                    end
                end
                HDR_HI: begin
                    if (xfer) count[15:8] <= bus.rx_data;
                end
                HDR_LO: begin
                    if (xfer) begin
                        count[7:0] <= bus.rx_data;
                        byte_idx   <= 2'd0;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        // Big-endian: the first byte ends up in bits 31:24.
                        shift <= {shift[23:0], bus.rx_data};
                        if (byte_idx != 2'd3) byte_idx <= byte_idx + 2'd1;
                    end
                end
                WRITE: begin
                    word_idx     <= word_idx_inc;
                    words_loaded <= words_loaded + 16'd1;
                    byte_idx     <= 2'd0;
                end
                RUN: begin
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Memory port: CPU pass-through in RUN, loader-owned otherwise.
    // busy is a registered copy of (state != RUN), so it selects the owner.
    // -----------------------------------------------------------------------
    assign bus.rx_ready     = rx_ready_q;
    assign bus.mem_address  = busy ? (BASE_ADDR + word_idx) : bus.cpu_address;
    assign bus.mem_data_out = busy ? shift                  : bus.cpu_data_out;
    assign bus.mem_we       = busy ? write_q                : bus.cpu_we;

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//
// Two loaders share one clock: dut_a (BASE_ADDR=0, BOOT_LOAD=1) and
// dut_b (BASE_ADDR=16'hFFFF, BOOT_LOAD=0). A small memory per DUT records
// every mem_we write; the expected image is derived from the byte stream.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    typedef logic [7:0] bq_t [$];

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_a, rst_b;
    logic        load_req_a, load_req_b;
    logic        cpu_reset_a, cpu_reset_b;
    logic        busy_a, busy_b;
    logic [15:0] wl_a, wl_b;

    prog_loader_if bus_a ();
    prog_loader_if bus_b ();

    prog_loader #(.BASE_ADDR(16'h0000), .BOOT_LOAD(1'b1)) dut_a (
        .clock        (clock),
        .reset        (rst_a),
        .load_req     (load_req_a),
        .bus          (bus_a.slave),
        .cpu_reset    (cpu_reset_a),
        .busy         (busy_a),
        .words_loaded (wl_a)
    );

    prog_loader #(.BASE_ADDR(16'hFFFF), .BOOT_LOAD(1'b0)) dut_b (
        .clock        (clock),
        .reset        (rst_b),
        .load_req     (load_req_b),
        .bus          (bus_b.slave),
        .cpu_reset    (cpu_reset_b),
        .busy         (busy_b),
        .words_loaded (wl_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] mem_a [int];
    logic [31:0] mem_b [int];
    int we_a = 0, we_b = 0;
    int wr_rdy_a = 0;

    // Memory models and write monitors.
    always @(posedge clock) begin
        cyc++;
        if (bus_a.mem_we === 1'b1) begin
            mem_a[int'(bus_a.mem_address)] = bus_a.mem_data_out;
            we_a++;
            if (bus_a.rx_ready !== 1'b0) wr_rdy_a++;
        end
        if (bus_b.mem_we === 1'b1) begin
            mem_b[int'(bus_b.mem_address)] = bus_b.mem_data_out;
            we_b++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd(input int d, input int a);
        if (d == 0) return mem_a.exists(a) ? mem_a[a] : 32'hxxxxxxxx;
        return mem_b.exists(a) ? mem_b[a] : 32'hxxxxxxxx;
    endfunction

    function automatic logic rdy(input int d);
        return (d == 0) ? bus_a.rx_ready : bus_b.rx_ready;
    endfunction

    function automatic logic bsy(input int d);
        return (d == 0) ? busy_a : busy_b;
    endfunction

    task automatic drive(input int d, input logic v, input logic [7:0] b);
        if (d == 0) begin
            bus_a.rx_valid = v;
            bus_a.rx_data  = b;
        end else begin
            bus_b.rx_valid = v;
            bus_b.rx_data  = b;
        end
    endtask

    // Offer one byte (after 'gap' idle cycles) and return on the negedge
    // following the edge that accepted it.
    task automatic send_byte(input int d, input logic [7:0] b, input int gap);
        int n;
        n = 0;
        repeat (gap) begin
            drive(d, 1'b0, 8'($urandom));
            @(negedge clock);
        end
        drive(d, 1'b1, b);
        while (rdy(d) !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (rdy(d) !== 1'b1) begin
            check("rx_ready_wait", {31'd0, rdy(d)}, 32'd1);
        end else begin
            @(negedge clock);
        end
        drive(d, 1'b0, 8'($urandom));
    endtask

    // mode 0: back-to-back, 1: one idle cycle before each byte, 2: random gaps
    task automatic send_stream(input int d, input bq_t s, input int mode);
        foreach (s[i]) begin
            send_byte(d, s[i], (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2)));
        end
    endtask

    task automatic pulse_load(input int d);
        @(negedge clock);
        if (d == 0) load_req_a = 1'b1; else load_req_b = 1'b1;
        @(negedge clock);
        @(negedge clock);
        if (d == 0) load_req_a = 1'b0; else load_req_b = 1'b0;
    endtask

    task automatic wait_run(input int d, input string tag);
        int n;
        n = 0;
        while (bsy(d) !== 1'b0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(tag, {31'd0, bsy(d)}, 32'd0);
    endtask

    // Build a stream: count header followed by n words.
    function automatic bq_t make_stream(input logic [31:0] words [$]);
        bq_t s;
        s.push_back(8'(words.size() >> 8));
        s.push_back(8'(words.size()));
        foreach (words[i]) begin
            s.push_back(words[i][31:24]);
            s.push_back(words[i][23:16]);
            s.push_back(words[i][15:8]);
            s.push_back(words[i][7:0]);
        end
        return s;
    endfunction

    // Reference: word i of the stream is bytes 2+4i..5+4i, stored at base+i mod 2^16.
    task automatic check_image(input int d, input bq_t s, input logic [15:0] base, input string tag);
        int          n;
        logic [31:0] w;
        logic [15:0] a;
        n = int'({s[0], s[1]});
        for (int i = 0; i < n; i++) begin
            w = {s[2 + 4*i], s[3 + 4*i], s[4 + 4*i], s[5 + 4*i]};
            a = base + 16'(i);
            check($sformatf("%s_w%0d", tag, i), rd(d, int'(a)), w);
        end
    endtask

    initial begin
        bq_t          s1, s;
        logic [31:0]  words [$];
        int           c0, we0, n;
        logic [31:0]  w0, w1;

        rst_a = 1'b0;
        rst_b = 1'b0;
        load_req_a = 1'b0;
        load_req_b = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        bus_a.cpu_address = 16'h0; bus_a.cpu_data_out = 32'h0; bus_a.cpu_we = 1'b0;
        bus_b.cpu_address = 16'h0; bus_b.cpu_data_out = 32'h0; bus_b.cpu_we = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clock);
        check("rst_cpu_reset", {31'd0, cpu_reset_a}, 32'd1);
        check("rst_busy",      {31'd0, busy_a},      32'd1);
        check("rst_rx_ready",  {31'd0, bus_a.rx_ready}, 32'd0);
        check("rst_mem_we",    {31'd0, bus_a.mem_we},   32'd0);
        check("rst_words",     {16'd0, wl_a},        32'd0);

        // ---- directed back-to-back load on A ----
        rst_a = 1'b1;
        rst_b = 1'b1;
        c0 = cyc;
        check("hold_cpu_reset", {31'd0, cpu_reset_a}, 32'd1);
        s1 = '{8'h00, 8'h02, 8'h40, 8'h00, 8'h00, 8'h05, 8'h80, 8'h00, 8'h00, 8'h00};
        send_stream(0, s1, 0);
        check("last_write_we",  {31'd0, bus_a.mem_we},   32'd1);
        check("last_write_rdy", {31'd0, bus_a.rx_ready}, 32'd0);
        @(negedge clock);
        check("b2b_busy",      {31'd0, busy_a},      32'd0);
        check("b2b_cpu_reset", {31'd0, cpu_reset_a}, 32'd0);
        check("b2b_words",     {16'd0, wl_a},        32'd2);
        check("b2b_cycles",    32'(cyc - c0),        32'd13);
        check("b2b_pulses",    32'(we_a),            32'd2);
        check("b2b_w0_const",  rd(0, 0),             32'h40000005);
        check_image(0, s1, 16'h0000, "b2b");
        check("b_boot_run",    {30'd0, busy_b, cpu_reset_b}, 32'd0);

        // ---- RUN pass-through, then re-enter load ----
        bus_a.cpu_we = 1'b1;
        bus_a.cpu_address = 16'h0010;
        bus_a.cpu_data_out = 32'hDEADBEEF;
        #1;
        check("pass_addr", {16'd0, bus_a.mem_address}, 32'h0010);
        check("pass_data", bus_a.mem_data_out,         32'hDEADBEEF);
        check("pass_we",   {31'd0, bus_a.mem_we},      32'd1);
        @(negedge clock);
        load_req_a = 1'b1;
        @(negedge clock);
        load_req_a = 1'b0;
        check("lreq_cpu_reset", {31'd0, cpu_reset_a},    32'd1);
        check("lreq_rdy_hold",  {31'd0, bus_a.rx_ready}, 32'd0);
        check("lreq_we_ignored",{31'd0, bus_a.mem_we},   32'd0);
        @(negedge clock);
        check("lreq_rdy_hdr",   {31'd0, bus_a.rx_ready}, 32'd1);
        check("lreq_we_ign2",   {31'd0, bus_a.mem_we},   32'd0);
        check("lreq_words_clr", {16'd0, wl_a},           32'd0);
        bus_a.cpu_we = 1'b0;

        // ---- same stream with toggling rx_valid ----
        mem_a.delete(0);
        mem_a.delete(1);
        we0 = we_a;
        send_stream(0, s1, 1);
        wait_run(0, "tog_run");
        check_image(0, s1, 16'h0000, "tog");
        check("tog_pulses",   32'(we_a - we0), 32'd2);
        check("tog_words",    {16'd0, wl_a},   32'd2);
        check("write_no_rdy", 32'(wr_rdy_a),   32'd0);

        // ---- empty image ----
        pulse_load(0);
        we0 = we_a;
        send_stream(0, '{8'h00, 8'h00}, 0);
        check("empty_busy",   {31'd0, busy_a}, 32'd0);
        check("empty_words",  {16'd0, wl_a},   32'd0);
        check("empty_pulses", 32'(we_a - we0), 32'd0);

        // ---- random loads on A ----
        for (int it = 0; it < 5; it++) begin
            n = int'($urandom_range(1, 6));
            words = {};
            for (int i = 0; i < n; i++) begin
                words.push_back($urandom);
                mem_a.delete(i);
            end
            s = make_stream(words);
            pulse_load(0);
            we0 = we_a;
            send_stream(0, s, 2);
            wait_run(0, $sformatf("rnd%0d_run", it));
            check_image(0, s, 16'h0000, $sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_words", it),  {16'd0, wl_a},   32'(n));
            check($sformatf("rnd%0d_pulses", it), 32'(we_a - we0), 32'(n));
        end
        check("rnd_write_no_rdy", 32'(wr_rdy_a), 32'd0);

        // ---- address wrap on B ----
        w0 = $urandom;
        w1 = $urandom;
        words = '{w0, w1};
        s = make_stream(words);
        pulse_load(1);
        we0 = we_b;
        send_stream(1, s, 2);
        wait_run(1, "wrap_run");
        check("wrap_ffff",   rd(1, 32'hFFFF), w0);
        check("wrap_0000",   rd(1, 0),        w1);
        check_image(1, s, 16'hFFFF, "wrap");
        check("wrap_words",  {16'd0, wl_b},   32'd2);
        check("wrap_pulses", 32'(we_b - we0), 32'd2);

        // ---- reset in the middle of word 1 on A ----
        w0 = $urandom;
        w1 = $urandom;
        words = '{w0, w1, 32'($urandom)};
        s = make_stream(words);
        while (s.size() > 8) void'(s.pop_back());
        mem_a.delete(0);
        pulse_load(0);
        we0 = we_a;
        send_stream(0, s, 0);
        #2;
        rst_a = 1'b0;
        #1;
        check("mid_cpu_reset", {31'd0, cpu_reset_a},    32'd1);
        check("mid_rx_ready",  {31'd0, bus_a.rx_ready}, 32'd0);
        check("mid_words",     {16'd0, wl_a},           32'd0);
        check("mid_pulses",    32'(we_a - we0),         32'd1);
        @(negedge clock);
        rst_a = 1'b1;
        check("mid_w0_kept", rd(0, 0), w0);
        @(negedge clock);
        check("restart_rdy",   {31'd0, bus_a.rx_ready}, 32'd1);
        check("restart_words", {16'd0, wl_a},           32'd0);
        words = '{w1};
        s = make_stream(words);
        send_stream(0, s, 2);
        wait_run(0, "restart_run");
        check_image(0, s, 16'h0000, "restart");
        check("restart_words_done", {16'd0, wl_a}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
